program_loader: RTL and testbench

- Writer side of the instruction store. Receives the program image as a big-endian byte stream over a valid/ready handshake and assembles 32-bit words.
- Writes the words sequentially into the instruction memory write port.
- Holds the core in reset while loading and pulses done when the image is complete.
- Byte order matches the on-disk image: the first byte of each group of four goes to [31:24].

---
 rtl/program_loader.sv | 180 ++++++++++++++++++
 tb/tb_program_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Instruction-store writer: assembles a big-endian byte stream into 32-bit words and writes them sequentially.
// Optional LOADER_CHECKSUM_EN adds a running 32-bit sum of every written word on output checksum.
module program_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          COUNT_W   = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic               overflow,
    output logic [COUNT_W-1:0] word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]        checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [31:0]          r_word;
    logic [1:0]           r_idx;
    logic                 r_last;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]          r_checksum;
`endif

    logic                 w_accept;
    logic                 w_word_end;
    logic                 w_room;
    logic [31:0]          w_byte_word;
    logic [31:0]          w_word_next;

    assign w_accept    = (r_state == S_RECV) && in_valid;
    assign w_word_end  = w_accept && ((r_idx == 2'd3) || in_last);
    assign w_room      = r_count < COUNT_W'(DEPTH);
    assign w_word_next = r_word | w_byte_word;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_byte_word = '0;
        case (r_idx)
            2'd0: w_byte_word[31:24] = in_data;
            2'd1: w_byte_word[23:16] = in_data;
            2'd2: w_byte_word[15:8]  = in_data;
            2'd3: w_byte_word[7:0]   = in_data;
            default: w_byte_word = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RECV;
                end
            end
            S_RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_word_end) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                busy         = 1'b1;
                mem_we       = w_room;
                w_next_state = r_last ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_word     <= '0;
                        r_idx      <= '0;
                        r_last     <= 1'b0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_checksum <= '0;
`endif
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_word <= w_word_next;
                        r_idx  <= r_idx + 2'd1;
                    end
                    // Address/data are staged on the closing byte so they are registered during WRITE.
                    if (w_word_end) begin
                        r_last <= in_last;
                        if (w_room) begin
                            r_mem_addr  <= BASE_ADDR + (32'(r_count) << 2);
                            r_mem_wdata <= w_word_next;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_room) begin
                        r_count    <= r_count + COUNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        r_checksum <= r_checksum + r_word;
`endif
                    end else begin
                        r_overflow <= 1'b1;
                    end
                    r_word <= '0;
                    r_idx  <= '0;
                    r_last <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cpu_hold   = busy;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign overflow   = r_overflow;
    assign word_count = r_count;
`ifdef LOADER_CHECKSUM_EN
    assign checksum   = r_checksum;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a cycle table for a two-word load plus sequences for partial words,
// handshake gaps, overflow (second instance with DEPTH=4, BASE_ADDR=0x100), mid-load reset and checksum.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [7:0]  in_data;

    logic        a_in_ready, a_mem_we, a_busy, a_cpu_hold, a_done, a_overflow;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [10:0] a_word_count;
    logic        b_in_ready, b_mem_we, b_busy, b_cpu_hold, b_done, b_overflow;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [2:0]  b_word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] a_checksum, b_checksum;
`endif

    program_loader dut_a (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(a_in_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .busy(a_busy), .cpu_hold(a_cpu_hold), .done(a_done), .overflow(a_overflow),
        .word_count(a_word_count)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(a_checksum)
`endif
    );

    program_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0100), .COUNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .busy(b_busy), .cpu_hold(b_cpu_hold), .done(b_done), .overflow(b_overflow),
        .word_count(b_word_count)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(b_checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cycles  = 0;
    int rdy_viol = 0;
    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];

    // Write capture and in_ready sanity, sampled on the falling edge.
    always @(negedge clk) begin
        if (a_mem_we === 1'b1) wq_a.push_back({a_mem_addr, a_mem_wdata});
        if (b_mem_we === 1'b1) wq_b.push_back({b_mem_addr, b_mem_wdata});
        if ((a_mem_we === 1'b1 || a_done === 1'b1) && a_in_ready !== 1'b0) rdy_viol++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input bit gaps);
        int  waited = 0;
        bit  ok     = 1'b0;
        while (!ok && waited < 20) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                tick();
            end else begin
                in_valid = 1'b1;
                in_data  = d;
                in_last  = l;
                ok       = a_in_ready;
                tick();
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            waited++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send timeout: byte %h never accepted", d);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (a_done === 1'b1) seen = 1'b1;
            else tick();
        end
        check({name, " done seen"}, 64'(seen), 64'd1);
        check({name, " done b"}, 64'(b_done), 64'd1);
        check({name, " hold low at done"}, 64'(a_cpu_hold), 64'd0);
        tick();
        check({name, " done one cycle"}, 64'(a_done), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " a addr/data"}, {a_mem_addr, a_mem_wdata}, 64'd0);
        check({name, " a ctrl"}, 64'({a_in_ready, a_mem_we, a_busy, a_cpu_hold, a_done, a_overflow, a_word_count}), 64'd0);
        check({name, " b ctrl"}, 64'({b_in_ready, b_mem_we, b_busy, b_cpu_hold, b_done, b_overflow, b_word_count, b_mem_addr}), 64'd0);
    endtask

    typedef struct {
        logic        start;
        logic        valid;
        logic        last;
        logic [7:0]  data;
        logic        e_ready;
        logic        e_we;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [10:0] e_wc;
    } vec_t;

    vec_t vecs[13];
    logic [7:0]  img8[8];
    logic [31:0] w;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;

        //        start valid last data   ready we busy done addr     wdata          wc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        11'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h00000013, 11'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h93, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h00100093, 11'd1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,        11'd2};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        11'd2};

        img8[0] = 8'h00; img8[1] = 8'h00; img8[2] = 8'h00; img8[3] = 8'h13;
        img8[4] = 8'h00; img8[5] = 8'h10; img8[6] = 8'h00; img8[7] = 8'h93;

        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full words, cycle by cycle
        wq_a.delete(); wq_b.delete(); rdy_viol = 0;
        for (int i = 0; i < 13; i++) begin
            start = vecs[i].start; in_valid = vecs[i].valid; in_last = vecs[i].last; in_data = vecs[i].data;
            check($sformatf("vec%0d ctrl", i),
                  64'({a_in_ready, a_mem_we, a_busy, a_cpu_hold, a_done, a_overflow, a_word_count}),
                  64'({vecs[i].e_ready, vecs[i].e_we, vecs[i].e_busy, vecs[i].e_busy, vecs[i].e_done, 1'b0, vecs[i].e_wc}));
            if (vecs[i].e_we)
                check($sformatf("vec%0d write", i), {a_mem_addr, a_mem_wdata}, {vecs[i].e_addr, vecs[i].e_wdata});
            tick();
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("full writes count", 64'(wq_a.size()), 64'd2);

        // Partial final word
        wq_a.delete(); wq_b.delete();
        do_start();
        send(8'hAA, 1'b0, 1'b0); send(8'hBB, 1'b0, 1'b0); send(8'hCC, 1'b0, 1'b0);
        send(8'hDD, 1'b0, 1'b0); send(8'hEE, 1'b1, 1'b0);
        wait_done("partial");
        check("partial count", 64'(wq_a.size()), 64'd2);
        if (wq_a.size() == 2) begin
            check("partial w0", wq_a[0], {32'h0, 32'hAABBCCDD});
            check("partial w1", wq_a[1], {32'h4, 32'hEE000000});
        end
        check("partial wc/ovf", 64'({a_word_count, a_overflow}), 64'({11'd2, 1'b0}));

        // Handshake gaps
        wq_a.delete(); wq_b.delete(); rdy_viol = 0;
        do_start();
        for (int i = 0; i < 8; i++) send(img8[i], (i == 7), 1'b1);
        wait_done("gaps");
        check("gaps count", 64'(wq_a.size()), 64'd2);
        if (wq_a.size() == 2) begin
            check("gaps w0", wq_a[0], {32'h0, 32'h00000013});
            check("gaps w1", wq_a[1], {32'h4, 32'h00100093});
        end
        check("gaps in_ready during write/done", 64'(rdy_viol), 64'd0);
        check("gaps wc", 64'(a_word_count), 64'd2);

        // Overflow on the DEPTH=4 instance, continuous valid
        wq_a.delete(); wq_b.delete();
        do_start();
        cycles = 0;
        for (int i = 0; i < 20; i++) send(8'(8'h10 + i), (i == 19), 1'b0);
        check("ovf drain cycles", 64'(cycles), 64'd24);
        wait_done("ovf");
        check("ovf b count", 64'(wq_b.size()), 64'd4);
        for (int k = 0; k < 4 && k < wq_b.size(); k++) begin
            w = {8'(16 + 4*k), 8'(17 + 4*k), 8'(18 + 4*k), 8'(19 + 4*k)};
            check($sformatf("ovf b w%0d", k), wq_b[k], {32'h100 + 32'(4*k), w});
        end
        check("ovf b flags", 64'({b_overflow, b_word_count}), 64'({1'b1, 3'd4}));
        check("ovf a flags", 64'({a_overflow, a_word_count}), 64'({1'b0, 11'd5}));

        // Mid-load reset
        wq_a.delete(); wq_b.delete();
        do_start();
        send(8'h77, 1'b0, 1'b0); send(8'h88, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        check("midrst no write", 64'(wq_a.size() + wq_b.size()), 64'd0);
        do_start();
        send(8'h01, 1'b0, 1'b0); send(8'h02, 1'b0, 1'b0); send(8'h03, 1'b0, 1'b0); send(8'h04, 1'b1, 1'b0);
        wait_done("midrst reload");
        check("midrst count", 64'(wq_a.size()), 64'd1);
        if (wq_a.size() == 1) check("midrst w0", wq_a[0], {32'h0, 32'h01020304});
        check("midrst b w0", (wq_b.size() == 1) ? wq_b[0] : 64'd0, {32'h100, 32'h01020304});

`ifdef LOADER_CHECKSUM_EN
        do_start();
        for (int i = 0; i < 12; i++)
            send((i == 3) ? 8'h01 : (i == 7) ? 8'h02 : (i >= 8) ? 8'hFF : 8'h00, (i == 11), 1'b0);
        wait_done("csum");
        check("csum after done", 64'(a_checksum), 64'h2);
        do_start();
        check("csum cleared by start", 64'(a_checksum), 64'h0);
        in_valid = 1'b1; in_last = 1'b1; in_data = 8'h00;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        wait_done("csum flush");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
